// File: rtl/hv_dim_accumulator_if.sv
// Handshake and data bundle between the encoder sequencer, the upstream
// adder tree/product source and the hypervector consumer.
interface hv_dim_accumulator_if #(
  parameter int DIM_WIDTH  = 16,
  parameter int NUM_DIMS   = 64,
  parameter int NUM_CHUNKS = 4
);
  localparam int CW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int DW = $clog2(NUM_DIMS);

  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic [CW-1:0]        chunk_idx;
  logic [DW-1:0]        dim_idx;
  logic [DIM_WIDTH-1:0] last_in;
  logic [DIM_WIDTH-1:0] tree_out;
  logic [NUM_DIMS-1:0]  hv_out;
  logic                 hv_valid;
  logic                 hv_ready;
  logic                 busy;

  // master: the surrounding datapath (tree, feature source, consumer)
  modport master (
    output start, in_valid, tree_out, hv_ready,
    input  in_ready, chunk_idx, dim_idx, last_in, hv_out, hv_valid, busy
  );

  // slave: the accumulator block itself
  modport slave (
    input  start, in_valid, tree_out, hv_ready,
    output in_ready, chunk_idx, dim_idx, last_in, hv_out, hv_valid, busy
  );
endinterface

// File: rtl/hv_dim_accumulator.sv
// Sequences (chunk, dim) pairs through the adder tree, folds each registered
// tree result back into a per-dimension accumulator and binarizes the last chunk.
module hv_dim_accumulator #(
  parameter int DIM_WIDTH  = 16,
  parameter int NUM_DIMS   = 64,
  parameter int NUM_CHUNKS = 4
) (
  input logic                 clk,
  input logic                 reset,
  hv_dim_accumulator_if.slave bus
);
  localparam int CW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int DW = $clog2(NUM_DIMS);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NUM_CHUNKS - 1);
  localparam logic [DW-1:0] LAST_DIM   = DW'(NUM_DIMS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e               state_q;
  logic                 in_ready_q;
  logic                 hv_valid_q;
  logic                 busy_q;
  logic [CW-1:0]        chunk_q;
  logic [DW-1:0]        dim_q;

  logic                 wr_en_q;
  logic [DW-1:0]        wr_dim_q;
  logic                 wr_last_q;
  logic [NUM_DIMS-1:0]  hv_q;
  logic [DIM_WIDTH-1:0] acc_q [NUM_DIMS];

  logic accept;
  logic dim_wrap;

  assign accept   = bus.in_valid && in_ready_q;
  assign dim_wrap = (dim_q == LAST_DIM);

  // Sequencer; handshake outputs are registered alongside the state so they
  // switch exactly with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      hv_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      chunk_q    <= '0;
      dim_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q    <= S_RUN;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            chunk_q    <= '0;
            dim_q      <= '0;
          end
        end
        S_RUN: begin
          if (accept) begin
            dim_q <= dim_wrap ? '0 : dim_q + 1'b1;
            if (dim_wrap) begin
              if (chunk_q == LAST_CHUNK) begin
                chunk_q    <= '0;
                state_q    <= S_DRAIN;
                in_ready_q <= 1'b0;
              end else begin
                chunk_q <= chunk_q + 1'b1;
              end
            end
          end
        end
        S_DRAIN: begin
          state_q    <= S_DONE;
          hv_valid_q <= 1'b1;
        end
        S_DONE: begin
          if (bus.hv_ready) begin
            state_q    <= S_IDLE;
            hv_valid_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          hv_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // Write-back pipe: remembers which dim the tree is summing this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_dim_q  <= '0;
      wr_last_q <= 1'b0;
      hv_q      <= '0;
    end else begin
      wr_en_q <= accept;
      if (accept) begin
        wr_dim_q  <= dim_q;
        wr_last_q <= (chunk_q == LAST_CHUNK);
      end
      if (wr_en_q && wr_last_q)
        hv_q[wr_dim_q] <= ~bus.tree_out[DIM_WIDTH-1];
    end
  end

  // Accumulator words are left unreset: chunk 0 never reads them.
  always_ff @(posedge clk) begin
    if (wr_en_q)
      acc_q[wr_dim_q] <= bus.tree_out;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.hv_valid  = hv_valid_q;
  assign bus.busy      = busy_q;
  assign bus.chunk_idx = chunk_q;
  assign bus.dim_idx   = dim_q;
  assign bus.hv_out    = hv_q;
  assign bus.last_in   = (chunk_q == '0) ? '0 : acc_q[dim_q];
endmodule

// File: tb/tb_hv_dim_accumulator.sv
// Randomized bench: a registered adder-tree model feeds the block, and a
// per-dimension modular sum over all chunks predicts every hv bit.
module tb_hv_dim_accumulator;
  localparam int DIMW = 16;
  localparam int ND   = 4;
  localparam int NC   = 2;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  hv_dim_accumulator_if #(.DIM_WIDTH(DIMW), .NUM_DIMS(ND), .NUM_CHUNKS(NC)) ifc ();

  hv_dim_accumulator #(.DIM_WIDTH(DIMW), .NUM_DIMS(ND), .NUM_CHUNKS(NC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // products presented for each (chunk, dim); tree = last_in + sum, 1-cycle reg
  logic [DIMW-1:0] prod [NC][ND][16];
  logic [DIMW-1:0] tree_d;

  always_comb begin
    tree_d = ifc.last_in;
    for (int k = 0; k < 16; k++)
      tree_d = tree_d + prod[ifc.chunk_idx][ifc.dim_idx][k];
  end

  always @(posedge clk) ifc.tree_out <= tree_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DIMW-1:0] prefix(input int c, input int d);
    logic [DIMW-1:0] s;
    s = '0;
    for (int cc = 0; cc < c; cc++)
      for (int k = 0; k < 16; k++) s = s + prod[cc][d][k];
    return s;
  endfunction

  function automatic logic [ND-1:0] model_hv();
    logic [ND-1:0]   hv;
    logic [DIMW-1:0] s;
    for (int d = 0; d < ND; d++) begin
      s     = prefix(NC, d);
      hv[d] = ~s[DIMW-1];
    end
    return hv;
  endfunction

  task automatic fill(input int mode);
    for (int c = 0; c < NC; c++)
      for (int d = 0; d < ND; d++)
        for (int k = 0; k < 16; k++)
          prod[c][d][k] = (mode == 0) ? 16'd1 : DIMW'($urandom);
  endtask

  task automatic fill_zero();
    for (int c = 0; c < NC; c++)
      for (int d = 0; d < ND; d++)
        for (int k = 0; k < 16; k++) prod[c][d][k] = '0;
  endtask

  // One full sample; all driving and sampling happens on negedges.
  task automatic run_sample(input bit stall, input int rdy_wait, input logic [ND-1:0] exp_hv);
    int n;
    int cyc;
    ifc.hv_ready = (rdy_wait == 0);
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    chk("run_busy", 64'(ifc.busy), 64'(1));
    chk("run_in_ready", 64'(ifc.in_ready), 64'(1));
    n   = 0;
    cyc = 0;
    while (n < NC * ND && cyc < 2000) begin
      ifc.in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("dim_idx", 64'(ifc.dim_idx), 64'(n % ND));
      chk("chunk_idx", 64'(ifc.chunk_idx), 64'(n / ND));
      if (ifc.in_valid && ifc.in_ready) begin
        chk("last_in", 64'(ifc.last_in), 64'(prefix(n / ND, n % ND)));
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    ifc.in_valid = 1'b0;
    if (n < NC * ND) chk("accept_timeout", 64'(n), 64'(NC * ND));
    chk("drain_hv_valid", 64'(ifc.hv_valid), 64'(0));
    chk("drain_in_ready", 64'(ifc.in_ready), 64'(0));
    @(negedge clk);
    chk("done_hv_valid", 64'(ifc.hv_valid), 64'(1));
    chk("hv_model", 64'(ifc.hv_out), 64'(model_hv()));
    chk("hv_expect", 64'(ifc.hv_out), 64'(exp_hv));
    for (int i = 0; i < rdy_wait; i++) begin
      ifc.start = 1'b1;
      @(negedge clk);
      chk("bp_hv_valid", 64'(ifc.hv_valid), 64'(1));
      chk("bp_in_ready", 64'(ifc.in_ready), 64'(0));
      chk("bp_hv_stable", 64'(ifc.hv_out), 64'(exp_hv));
    end
    ifc.start    = 1'b0;
    ifc.hv_ready = 1'b1;
    @(negedge clk);
    ifc.hv_ready = 1'b0;
    chk("idle_busy", 64'(ifc.busy), 64'(0));
    chk("idle_hv_valid", 64'(ifc.hv_valid), 64'(0));
    chk("idle_hv_hold", 64'(ifc.hv_out), 64'(exp_hv));
  endtask

  initial begin
    logic [ND-1:0] exp;
    int s0 [ND];
    int s1 [ND];
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    ifc.start    = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.hv_ready = 1'b0;
    fill_zero();
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(ifc.busy), 64'(0));
    chk("rst_in_ready", 64'(ifc.in_ready), 64'(0));
    chk("rst_hv_valid", 64'(ifc.hv_valid), 64'(0));
    chk("rst_hv_out", 64'(ifc.hv_out), 64'(0));
    chk("rst_last_in", 64'(ifc.last_in), 64'(0));
    chk("rst_dim", 64'(ifc.dim_idx), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // all products +1: 16 per chunk, 32 total
    fill(0);
    run_sample(1'b0, 0, 4'b1111);

    // sign binarization with backpressure
    s0 = '{10, -10, 0, -1};
    s1 = '{-11, 11, 0, 1};
    fill_zero();
    for (int d = 0; d < ND; d++) begin
      prod[0][d][0] = DIMW'(s0[d]);
      prod[1][d][0] = DIMW'(s1[d]);
    end
    run_sample(1'b0, 10, 4'b1110);

    // random products, unstalled then stalled against the same prediction
    fill(1);
    exp = model_hv();
    run_sample(1'b0, 0, exp);
    run_sample(1'b1, 3, exp);

    // wrap: per-chunk sums of 0x9000/0x6000/0x4000, totals wrap modulo 2^16
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < 16; k++) begin
        prod[c][0][k] = 16'h0900;
        prod[c][1][k] = 16'h0600;
        prod[c][2][k] = 16'h0400;
        prod[c][3][k] = 16'hFF80;
      end
    run_sample(1'b0, 0, 4'b0001);

    // reset in the middle of chunk 1
    fill(1);
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start    = 1'b0;
    ifc.in_valid = 1'b1;
    repeat (ND + 1) @(negedge clk);
    ifc.in_valid = 1'b0;
    chk("mid_chunk", 64'(ifc.chunk_idx), 64'(1));
    chk("mid_dim", 64'(ifc.dim_idx), 64'(1));
    reset = 1'b1;
    #1;
    chk("mrst_busy", 64'(ifc.busy), 64'(0));
    chk("mrst_in_ready", 64'(ifc.in_ready), 64'(0));
    chk("mrst_hv_valid", 64'(ifc.hv_valid), 64'(0));
    chk("mrst_hv_out", 64'(ifc.hv_out), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_sample(1'b1, 2, model_hv());

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
